// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: bubble word, reset PC,
// fetch FSM states and the IF/ID payload.
package fetch_pkg;

    // Instruction memory returns this word for empty locations; also the
    // canonical "no instruction" value carried down the pipe.
    localparam logic [31:0] BUBBLE       = 32'hFC00_0000;
    localparam logic [31:0] PC_RESET_DEF = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instru;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instru: BUBBLE, pc4: 32'd0, valid: 1'b0};

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Bubble has priority over load; otherwise holds.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t data_i,
    output if_id_t data_o
);

    if_id_t data_q, data_d;

    // Next payload: bubble overrides load, default is hold.
    always_comb begin
        data_d = data_q;
        if (bubble_i)    data_d = IF_ID_BUBBLE;
        else if (load_i) data_d = data_i;
    end

    // Payload register, cleared to a bubble on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= IF_ID_BUBBLE;
        else        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory address and loads
// the IF/ID register. Handles stall, flush, branch/jump redirect and halt
// on an empty word or on running off the end of instruction memory.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall/squash
// counters as extra outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 128,
    parameter logic [31:0] PC_RESET   = PC_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instru,
    output logic [31:0] if_id_instru,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] squash_cnt
`endif
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         halted_q, halted_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc4;
    logic         ifid_load, ifid_bubble;
    if_id_t       ifid_in, ifid_q;

    // Redirect select: branch is the older instruction, so it wins over jump.
    always_comb begin
        redirect = branch_taken_i | jump_i;
        target   = branch_taken_i ? branch_target_i : jump_target_i;
        target   = {target[31:2], 2'b00};
        pc4      = pc_q + 32'd4;
    end

    // Next-state, PC and IF/ID control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halted_d    = halted_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_in     = '{instru: imem_instru, pc4: pc4, valid: 1'b1};
        unique case (state_q)
            ST_INIT: begin
                pc_d        = 32'd0;
                ifid_bubble = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d        = target;
                    ifid_bubble = 1'b1;
                end else if (stall_i) begin
                    // hold PC and IF/ID; flush is meaningless while stalled
                end else if (imem_instru == BUBBLE) begin
                    ifid_bubble = 1'b1;
                    state_d     = ST_HALT;
                    halted_d    = 1'b1;
                end else begin
                    // Last word in memory still issues, then fetch stops.
                    if (pc4 >= IMEM_BYTES) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc4;
                    end
                    if (flush_i) ifid_bubble = 1'b1;
                    else         ifid_load   = 1'b1;
                end
            end
            ST_HALT: begin
                ifid_bubble = 1'b1;
                if (redirect) begin
                    pc_d     = target;
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_INIT;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    // State, PC and halted flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            pc_q     <= PC_RESET;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .data_i   (ifid_in),
        .data_o   (ifid_q)
    );

    assign imem_addr    = pc_q;
    assign if_id_instru = ifid_q.instru;
    assign if_id_pc4    = ifid_q.pc4;
    assign if_id_valid  = ifid_q.valid;
    assign halted       = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;
    logic        run, stall_evt, squash_evt;

    // Event decode and saturating counter updates.
    always_comb begin
        run          = (state_q == ST_RUN);
        stall_evt    = run && !redirect && stall_i;
        squash_evt   = run && (redirect ||
                       (!stall_i && flush_i && (imem_instru != BUBBLE)));
        fetch_cnt_d  = sat_inc(fetch_cnt_q, ifid_load);
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_evt);
        squash_cnt_d = sat_inc(squash_cnt_q, squash_evt);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= 32'd0;
            stall_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch rules. A second instance with a
// 4-word memory covers the end-of-memory halt.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int WORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i, flush_i, branch_taken_i, jump_i;
    logic [31:0] branch_target_i, jump_target_i;

    logic [31:0] a_addr, a_imem, a_instru, a_pc4;
    logic        a_valid, a_halted;
    logic [31:0] b_addr, b_imem, b_instru, b_pc4;
    logic        b_valid, b_halted;

    logic [31:0] mem  [WORDS];
    logic [31:0] mem4 [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction memories: out-of-range addresses read as the empty word.
    always_comb begin
        a_imem = BUBBLE;
        if (a_addr[31:2] < 30'(WORDS)) a_imem = mem[a_addr[8:2]];
        b_imem = BUBBLE;
        if (b_addr[31:2] < 30'd4) b_imem = mem4[b_addr[3:2]];
    end

    wire [97:0] obs_a = {a_addr, a_instru, a_pc4, a_valid, a_halted};
    wire [97:0] obs_b = {b_addr, b_instru, b_pc4, b_valid, b_halted};
    localparam logic [97:0] RST_VAL = {32'hFFFF_FFFC, 32'hFC00_0000, 32'h0, 1'b0, 1'b0};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] a_fcnt, a_scnt, a_qcnt, b_fcnt, b_scnt, b_qcnt;
`endif

    fetch_stage #(.IMEM_WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .imem_addr(a_addr), .imem_instru(a_imem),
        .if_id_instru(a_instru), .if_id_pc4(a_pc4), .if_id_valid(a_valid),
        .halted(a_halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(a_fcnt), .stall_cnt(a_scnt), .squash_cnt(a_qcnt)
`endif
    );

    fetch_stage #(.IMEM_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .imem_addr(b_addr), .imem_instru(b_imem),
        .if_id_instru(b_instru), .if_id_pc4(b_pc4), .if_id_valid(b_valid),
        .halted(b_halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(b_fcnt), .stall_cnt(b_scnt), .squash_cnt(b_qcnt)
`endif
    );

    // ---------------- behavioural model ----------------
    int          m_phase;   // 0 = first cycle after reset, 1 = fetching, 2 = stopped
    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_valid, m_halted;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a / 4 < WORDS) return mem[a[8:2]];
        return BUBBLE;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 32'hFFFF_FFFC;
        m_ins = BUBBLE; m_pc4 = 0; m_valid = 0; m_halted = 0;
    endtask

    task automatic model_bubble();
        m_ins = BUBBLE; m_pc4 = 0; m_valid = 0;
    endtask

    // One clock edge of fetch behaviour using the currently driven inputs.
    task automatic model_step();
        logic [31:0] tgt, w, nxt;
        logic        redir;
        redir = branch_taken_i || jump_i;
        tgt   = (branch_taken_i ? branch_target_i : jump_target_i) & ~32'd3;
        if (m_phase == 0) begin
            m_pc = 0; model_bubble(); m_phase = 1;
        end else if (m_phase == 2) begin
            model_bubble();
            if (redir) begin m_pc = tgt; m_phase = 1; m_halted = 0; end
        end else if (redir) begin
            m_pc = tgt; model_bubble();
        end else if (!stall_i) begin
            w   = mem_word(m_pc);
            nxt = m_pc + 4;
            if (w == BUBBLE) begin
                model_bubble(); m_phase = 2; m_halted = 1;
            end else begin
                if (flush_i) model_bubble();
                else begin m_ins = w; m_pc4 = nxt; m_valid = 1; end
                if (nxt >= 32'(WORDS * 4)) begin m_phase = 2; m_halted = 1; end
                else m_pc = nxt;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0;
        branch_target_i = 0; jump_target_i = 0;
    endtask

    task automatic reset_dut();
        rst_n = 0; clear_inputs(); tick(); tick();
        rst_n = 1; model_reset();
    endtask

    task automatic fill_linear();
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h2000_0000 + 32'(i * 16 + 3);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; clear_inputs(); tick(); tick();
        n_tests++;
        if (obs_a !== RST_VAL) begin n_fail++; $display("FAIL reset_a: got %h exp %h", obs_a, RST_VAL); end
        n_tests++;
        if (obs_b !== RST_VAL) begin n_fail++; $display("FAIL reset_b: got %h exp %h", obs_b, RST_VAL); end
    endtask

    task automatic test_fill_halt();
        fill_linear(); mem[3] = BUBBLE;
        reset_dut();
        n_tests++;
        if (a_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL fill_rstaddr: got %h exp fffffffc", a_addr); end
        tick();
        n_tests++;
        if (obs_a !== {32'h0, BUBBLE, 32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL fill_init: got %h", obs_a); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (obs_a !== {32'(4 * k), mem[k - 1], 32'(4 * k), 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL fill_word%0d: got %h exp %h", k, obs_a, {32'(4 * k), mem[k - 1], 32'(4 * k), 1'b1, 1'b0});
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (obs_a !== {32'hC, BUBBLE, 32'h0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL fill_halt%0d: got %h", k, obs_a); end
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++;
        if (a_fcnt !== 32'd3) begin n_fail++; $display("FAIL fill_fetch_cnt: got %0d exp 3", a_fcnt); end
`endif
    endtask

    // Continues from the halted state left by test_fill_halt.
    task automatic test_halt_jump();
        mem[4] = 32'h2400_1234;
        stall_i = 1; flush_i = 1; tick(); clear_inputs();
        n_tests++;
        if (obs_a !== {32'hC, BUBBLE, 32'h0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL halt_ignore: got %h", obs_a); end
        jump_i = 1; jump_target_i = 32'h13; tick(); clear_inputs();
        n_tests++;
        if (obs_a !== {32'h10, BUBBLE, 32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL halt_jump: got %h", obs_a); end
        tick();
        n_tests++;
        if (obs_a !== {32'h14, 32'h2400_1234, 32'h14, 1'b1, 1'b0}) begin n_fail++; $display("FAIL halt_resume: got %h", obs_a); end
    endtask

    task automatic test_stall();
        fill_linear();
        reset_dut(); tick(); tick(); tick();
        stall_i = 1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) flush_i = 1;
            tick();
            n_tests++;
            if (obs_a !== {32'h8, mem[1], 32'h8, 1'b1, 1'b0}) begin n_fail++; $display("FAIL stall%0d: got %h", k, obs_a); end
        end
        clear_inputs(); tick();
        n_tests++;
        if (obs_a !== {32'hC, mem[2], 32'hC, 1'b1, 1'b0}) begin n_fail++; $display("FAIL stall_release: got %h", obs_a); end
    endtask

    task automatic test_redirect_priority();
        branch_taken_i = 1; branch_target_i = 32'h20;
        jump_i = 1; jump_target_i = 32'h40; stall_i = 1;
        tick(); clear_inputs();
        n_tests++;
        if (obs_a !== {32'h20, BUBBLE, 32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL redirect_prio: got %h", obs_a); end
        tick();
        n_tests++;
        if (obs_a !== {32'h24, mem[8], 32'h24, 1'b1, 1'b0}) begin n_fail++; $display("FAIL redirect_next: got %h", obs_a); end
    endtask

    task automatic test_flush();
        fill_linear();
        reset_dut(); tick(); tick();
        flush_i = 1; tick(); clear_inputs();
        n_tests++;
        if (obs_a !== {32'h8, BUBBLE, 32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL flush: got %h", obs_a); end
        tick();
        n_tests++;
        if (obs_a !== {32'hC, mem[2], 32'hC, 1'b1, 1'b0}) begin n_fail++; $display("FAIL flush_next: got %h", obs_a); end
    endtask

    task automatic test_small_mem();
        for (int i = 0; i < 4; i++) mem4[i] = 32'h3000_0000 + 32'(i * 7 + 1);
        reset_dut(); tick();
        n_tests++;
        if (obs_b !== {32'h0, BUBBLE, 32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL small_init: got %h", obs_b); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (obs_b !== {32'(4 * k), mem4[k - 1], 32'(4 * k), 1'b1, 1'b0}) begin n_fail++; $display("FAIL small_word%0d: got %h", k, obs_b); end
        end
        tick();
        n_tests++;
        if (obs_b !== {32'hC, mem4[3], 32'h10, 1'b1, 1'b1}) begin n_fail++; $display("FAIL small_last: got %h", obs_b); end
        tick();
        n_tests++;
        if (obs_b !== {32'hC, BUBBLE, 32'h0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL small_halt: got %h", obs_b); end
    endtask

    task automatic test_reset_mid();
        fill_linear();
        reset_dut();
        repeat (6) tick();
        rst_n = 0; #2;
        n_tests++;
        if (obs_a !== RST_VAL) begin n_fail++; $display("FAIL midreset_a: got %h exp %h", obs_a, RST_VAL); end
        n_tests++;
        if (obs_b !== RST_VAL) begin n_fail++; $display("FAIL midreset_b: got %h exp %h", obs_b, RST_VAL); end
    endtask

    task automatic test_random();
        for (int i = 0; i < WORDS; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? BUBBLE : ($urandom & 32'h03FF_FFFF);
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            branch_taken_i  = ($urandom_range(0, 9) == 0);
            jump_i          = ($urandom_range(0, 9) == 0);
            stall_i         = ($urandom_range(0, 4) == 0);
            flush_i         = ($urandom_range(0, 5) == 0);
            branch_target_i = 32'($urandom_range(0, 'h23F));
            jump_target_i   = ($urandom_range(0, 15) == 0) ? 32'h1FC : 32'($urandom_range(0, 'h23F));
            model_step();
            tick();
            n_tests++;
            if (obs_a !== {m_pc, m_ins, m_pc4, m_valid, m_halted}) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h exp %h", c, obs_a, {m_pc, m_ins, m_pc4, m_valid, m_halted});
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < 4; i++) mem4[i] = 32'h1;
        fill_linear();
        test_reset();
        test_fill_halt();
        test_halt_jump();
        test_stall();
        test_redirect_priority();
        test_flush();
        test_small_mem();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF-stage control block that sits directly upstream of the instruction memory and downstream into ID.
- Owns the PC register and drives the instruction-memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect, and halt-on-empty-word detection for the 5-stage MIPS pipeline.

Parameters:
- IMEM_WORDS, 128, depth of instruction memory in 32-bit words; fetches at or beyond IMEM_WORDS*4 halt.
- PC_RESET, 32'hFFFF_FFFC, PC value held during reset; instruction memory returns the bubble word at this address.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  load-use stall from hazard unit; hold PC and IF/ID.
- flush_i  input  1  squash the instruction entering IF/ID; PC advances normally.
- branch_taken_i  input  1  taken branch resolved in EX.
- branch_target_i  input  32  branch target byte address.
- jump_i  input  1  jump decoded in ID.
- jump_target_i  input  32  jump target byte address.
- imem_addr  output  32  byte address to instruction memory (combinational copy of PC).
- imem_instru  input  32  instruction word returned combinationally by instruction memory.
- if_id_instru  output  32  registered instruction to ID.
- if_id_pc4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = if_id_instru is a real instruction.
- halted  output  1  fetch has stopped.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc = PC_RESET, state = INIT.
  - if_id_instru = 32'hFC00_0000 (BUBBLE), if_id_pc4 = 0, if_id_valid = 0, halted = 0.
- imem_addr = pc, purely combinational. No other output is combinational.
- States and transitions:
  - INIT: exactly one cycle after reset release. Sets pc <= 0, IF/ID <= BUBBLE, then goes to RUN. Inputs are ignored.
  - RUN, redirect: if branch_taken_i, redirect to branch_target_i. Else if jump_i, redirect to jump_target_i. Branch wins because it is the older instruction.
    - On redirect: pc <= {target[31:2],2'b00}, IF/ID <= BUBBLE.
    - Redirect overrides stall_i.
  - RUN, stall: else if stall_i, pc and IF/ID hold. flush_i is ignored while stalled.
  - RUN, halt: else if imem_instru == BUBBLE, or pc+4 >= IMEM_WORDS*4, then pc holds, IF/ID <= BUBBLE, state <= HALT, halted <= 1.
    - The pc+4 case: the current word is still loaded valid, then the block halts.
  - RUN, normal: else pc <= pc+4 (mod 2^32), IF/ID <= {imem_instru, pc+4, valid=1}. If flush_i, IF/ID <= BUBBLE with valid=0 and pc4=0.
  - HALT: pc holds, IF/ID holds BUBBLE, halted = 1.
    - A branch_taken_i or jump_i (an older in-flight instruction) returns to RUN: pc <= target, halted <= 0.
    - stall_i and flush_i have no effect in HALT.
- The halt check happens only in RUN without redirect, so a wrong-path empty word never halts.
- Reset mid-operation returns to the reset values immediately; no in-flight state survives.
- Width rules: all PC arithmetic is 32-bit unsigned and wraps. Target bits [1:0] are forced to 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0], stall_cnt[31:0], squash_cnt[31:0].
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
  - fetch_cnt counts valid IF/ID loads.
  - stall_cnt counts RUN cycles with stall_i and no redirect.
  - squash_cnt counts redirect and flush bubbles.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - BUBBLE = 32'hFC00_0000.
  - the PC_RESET default.
  - fetch state enum {INIT, RUN, HALT}.
  - the if_id payload struct {instru, pc4, valid}.
- One sub-module, if_id_reg: the IF/ID register with load/hold/bubble controls.
- The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset release, memory holds 3 words then the fill word: imem_addr goes FFFFFFFC, 0, 4, 8, 0xC. Three valid IF/ID words with pc4 4, 8, C. halted=1 on the next edge; imem_addr stays 0xC.
- stall_i high 2 cycles at pc=8: pc stays 8 and IF/ID holds the word from 4. On release pc goes to 0xC.
- branch_taken_i=1 with branch_target_i=0x20, jump_i=1 with jump_target_i=0x40, and stall_i=1, all in the same cycle: pc goes to 0x20 and IF/ID is BUBBLE with valid=0.
- flush_i=1 at pc=4 without stall: pc goes to 8 and IF/ID is BUBBLE.
- In HALT, jump_i with target 0x13: pc goes to 0x10, state RUN, halted=0.
- IMEM_WORDS=4 with all words non-empty: the word at 0xC loads valid, then halted=1 with pc held at 0xC. rst_n pulsed low mid-run: all outputs return to reset values asynchronously.
